// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state encoding for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA1 = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;
    localparam logic [3:0] OP_MUL  = 4'd13;
    localparam logic [3:0] OP_SRA  = 4'd14;
    localparam logic [3:0] OP_NOP  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/result handshake bundle between an ALU client (master) and the ALU (slave).
interface alu_pipe_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, ctrl, x, y, out_ready,
        input  in_ready, out_valid, out, out_hi, carry, ovf, zero
    );

    modport slave (
        input  in_valid, ctrl, x, y, out_ready,
        output in_ready, out_valid, out, out_hi, carry, ovf, zero
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps per product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;

    // Upper half accumulates; the multiplier shifts out of the lower half as the product shifts in.
    assign sum = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= a;
                product <= {{WIDTH{1'b0}}, b};
                cnt     <= CW'(WIDTH);
                busy    <= 1'b1;
            end else if (busy) begin
                product <= {sum, product[WIDTH-1:1]};
                cnt     <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// ALU with a registered result stage; MUL runs on a sequential multiplier.
//   state | meaning
//   IDLE  | accepting requests; single-cycle ops complete from here
//   MUL   | multiplier iterating, requests blocked
//   HOLD  | product presented, waiting for the consumer
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst_n,
    alu_pipe_if.slave bus
);

    state_t               state, state_nx;
    logic                 accept, load_alu, mul_start, mul_busy, mul_done, mul_fin;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH:0]       sum, diff;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     res;
    logic                 c_res, v_res;

    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_alu     = accept && (bus.ctrl != OP_MUL);
    assign mul_fin      = (state == MUL) && mul_done && !mul_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        case (state)
            IDLE: if (accept && bus.ctrl == OP_MUL) begin
                state_nx  = MUL;
                mul_start = 1'b1;
            end
            MUL:  if (mul_fin) state_nx = HOLD;
            HOLD: if (bus.out_valid && bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.x),
        .b       (bus.y),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign sum   = {1'b0, bus.x} + {1'b0, bus.y};
    assign diff  = {1'b0, bus.x} - {1'b0, bus.y};
    assign shamt = bus.x[SHW-1:0];

    always_comb begin
        res   = '0;
        c_res = 1'b0;
        v_res = 1'b0;
        case (bus.ctrl)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                c_res = sum[WIDTH];
                v_res = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                c_res = diff[WIDTH];
                v_res = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (diff[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_AND:  res = bus.x & bus.y;
            OP_OR:   res = bus.x | bus.y;
            OP_NOT:  res = ~bus.x;
            OP_XOR:  res = bus.x ^ bus.y;
            OP_NOR:  res = ~(bus.x | bus.y);
            OP_SLL:  res = bus.y << shamt;
            OP_SRL:  res = bus.y >> shamt;
            OP_SRA1: res = {bus.x[WIDTH-1], bus.x[WIDTH-1:1]};
            OP_ROL:  res = {bus.x[WIDTH-2:0], bus.x[WIDTH-1]};
            OP_ROR:  res = {bus.x[0], bus.x[WIDTH-1:1]};
            OP_EQ:   res = (bus.x == bus.y) ? WIDTH'(1) : '0;
            OP_SRA:  res = $signed(bus.y) >>> shamt;
            default: res = '0;
        endcase
    end

    // Consumption clears valid first so a same-cycle load can re-assert it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_hi    <= '0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            if (load_alu) begin
                bus.out_valid <= 1'b1;
                bus.out       <= res;
                bus.out_hi    <= '0;
                bus.carry     <= c_res;
                bus.ovf       <= v_res;
                bus.zero      <= (res == '0);
            end else if (mul_fin) begin
                bus.out_valid <= 1'b1;
                bus.out       <= mul_prod[WIDTH-1:0];
                bus.out_hi    <= mul_prod[2*WIDTH-1:WIDTH];
                bus.carry     <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                bus.ovf       <= 1'b0;
                bus.zero      <= (mul_prod[WIDTH-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 8-bit instance for most features, 16-bit instance for wide shifts.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(8))  b8 ();
    alu_pipe_if #(.WIDTH(16)) b16 ();

    alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    alu_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    localparam logic [3:0] LC [14] = '{OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NOR, OP_SLL, OP_SRL,
                                       OP_SRA1, OP_ROL, OP_ROR, OP_EQ, OP_EQ, OP_SRA, OP_NOP};
    localparam logic [7:0] LX [14] = '{8'hF0, 8'hF0, 8'h5A, 8'hFF, 8'hF0, 8'h0B, 8'h02,
                                       8'h81, 8'h81, 8'h81, 8'h33, 8'h33, 8'h03, 8'hFF};
    localparam logic [7:0] LY [14] = '{8'h3C, 8'h0F, 8'h00, 8'h0F, 8'h0F, 8'h01, 8'h80,
                                       8'h00, 8'h00, 8'h00, 8'h33, 8'h34, 8'h80, 8'hFF};
    localparam logic [7:0] LE [14] = '{8'h30, 8'hFF, 8'hA5, 8'hF0, 8'h00, 8'h08, 8'h20,
                                       8'hC0, 8'h03, 8'hC0, 8'h01, 8'h00, 8'hF0, 8'h00};

    // Called at a falling edge; returns at the next falling edge with the request taken.
    task automatic op8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        b8.ctrl     = c;
        b8.x        = a;
        b8.y        = b;
        b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({b8.out_valid, b8.carry, b8.ovf, b8.zero} !== 4'b0000 || b8.out !== 8'h00 || b8.out_hi !== 8'h00) begin
            n_fail++;
            $display("FAIL reset8_outputs got v/c/o/z=%b out=%h hi=%h exp 0000 00 00",
                     {b8.out_valid, b8.carry, b8.ovf, b8.zero}, b8.out, b8.out_hi);
        end
        n_tests++;
        if (b16.out_valid !== 1'b0 || b16.out !== 16'h0000 || b16.out_hi !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset16_outputs got v=%b out=%h hi=%h exp 0 0000 0000", b16.out_valid, b16.out, b16.out_hi);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (b8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b exp 1", b8.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        op8(OP_ADD, 8'hFF, 8'h01);
        n_tests++;
        if (b8.out_valid !== 1'b1 || b8.out !== 8'h00 || {b8.carry, b8.ovf, b8.zero} !== 3'b101 || b8.out_hi !== 8'h00) begin
            n_fail++;
            $display("FAIL add_ff_01 got v=%b out=%h c/o/z=%b exp 1 00 101", b8.out_valid, b8.out, {b8.carry, b8.ovf, b8.zero});
        end
        op8(OP_ADD, 8'h7F, 8'h01);
        n_tests++;
        if (b8.out !== 8'h80 || {b8.carry, b8.ovf, b8.zero} !== 3'b010) begin
            n_fail++;
            $display("FAIL add_7f_01 got out=%h c/o/z=%b exp 80 010", b8.out, {b8.carry, b8.ovf, b8.zero});
        end
    endtask

    task automatic test_sub();
        op8(OP_SUB, 8'h80, 8'h01);
        n_tests++;
        if (b8.out !== 8'h7F || {b8.carry, b8.ovf, b8.zero} !== 3'b010) begin
            n_fail++;
            $display("FAIL sub_80_01 got out=%h c/o/z=%b exp 7f 010", b8.out, {b8.carry, b8.ovf, b8.zero});
        end
        op8(OP_SUB, 8'h01, 8'h02);
        n_tests++;
        if (b8.out !== 8'hFF || {b8.carry, b8.ovf, b8.zero} !== 3'b100) begin
            n_fail++;
            $display("FAIL sub_01_02 got out=%h c/o/z=%b exp ff 100", b8.out, {b8.carry, b8.ovf, b8.zero});
        end
    endtask

    task automatic test_logic_shift();
        for (int i = 0; i < 14; i++) begin
            op8(LC[i], LX[i], LY[i]);
            n_tests++;
            if (b8.out_valid !== 1'b1 || b8.out !== LE[i] || b8.out_hi !== 8'h00 ||
                {b8.carry, b8.ovf} !== 2'b00 || b8.zero !== (LE[i] == 8'h00)) begin
                n_fail++;
                $display("FAIL op%0d_vec%0d got v=%b out=%h hi=%h c/o/z=%b exp out=%h z=%b",
                         LC[i], i, b8.out_valid, b8.out, b8.out_hi, {b8.carry, b8.ovf, b8.zero},
                         LE[i], (LE[i] == 8'h00));
            end
        end
    endtask

    task automatic test_back_to_back();
        b8.ctrl = OP_ADD; b8.x = 8'h01; b8.y = 8'h02; b8.in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (b8.out_valid !== 1'b1 || b8.out !== 8'h03 || b8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_add got v=%b out=%h rdy=%b exp 1 03 1", b8.out_valid, b8.out, b8.in_ready);
        end
        b8.ctrl = OP_XOR; b8.x = 8'h0F; b8.y = 8'h01;
        @(negedge clk);
        n_tests++;
        if (b8.out_valid !== 1'b1 || b8.out !== 8'h0E || b8.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_xor got v=%b out=%h rdy=%b exp 1 0e 1", b8.out_valid, b8.out, b8.in_ready);
        end
        b8.ctrl = OP_OR; b8.x = 8'h10; b8.y = 8'h01;
        @(negedge clk);
        b8.in_valid = 1'b0;
        n_tests++;
        if (b8.out_valid !== 1'b1 || b8.out !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_or got v=%b out=%h exp 1 11", b8.out_valid, b8.out);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int cyc;
        int busy_bad;
        cyc = 0;
        busy_bad = 0;
        op8(OP_MUL, 8'hFF, 8'hFF);
        // Requests and operand changes during the multiply must be ignored.
        b8.ctrl = OP_ADD; b8.x = 8'h12; b8.y = 8'h34; b8.in_valid = 1'b1;
        while (b8.out_valid !== 1'b1 && cyc < 20) begin
            if (b8.in_ready !== 1'b0) busy_bad++;
            @(negedge clk);
            cyc++;
        end
        b8.in_valid = 1'b0;
        n_tests++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL mul_latency got %0d cycles exp 9", cyc);
        end
        n_tests++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL mul_in_ready got %0d ready cycles exp 0", busy_bad);
        end
        n_tests++;
        if (b8.out !== 8'h01 || b8.out_hi !== 8'hFE || {b8.carry, b8.ovf, b8.zero} !== 3'b100) begin
            n_fail++;
            $display("FAIL mul_ff_ff got out=%h hi=%h c/o/z=%b exp 01 fe 100", b8.out, b8.out_hi, {b8.carry, b8.ovf, b8.zero});
        end
        @(negedge clk);
        n_tests++;
        if (b8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_no_queued got v=%b exp 0", b8.out_valid);
        end
    endtask

    task automatic test_backpressure();
        b8.out_ready = 1'b0;
        op8(OP_ADD, 8'h10, 8'h20);
        b8.ctrl = OP_NOP; b8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (b8.out_valid !== 1'b1 || b8.out !== 8'h30 || b8.in_ready !== 1'b0 || b8.zero !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d got v=%b out=%h rdy=%b z=%b exp 1 30 0 0", i, b8.out_valid, b8.out, b8.in_ready, b8.zero);
            end
            @(negedge clk);
        end
        b8.ctrl = OP_EQ; b8.x = 8'h5A; b8.y = 8'h5A; b8.out_ready = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        n_tests++;
        if (b8.out_valid !== 1'b1 || b8.out !== 8'h01) begin
            n_fail++;
            $display("FAIL eq_after_stall got v=%b out=%h exp 1 01", b8.out_valid, b8.out);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_reset();
        int stale;
        stale = 0;
        op8(OP_MUL, 8'h0F, 8'h0F);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (b8.out_valid !== 1'b0 || b8.out !== 8'h00) begin
            n_fail++;
            $display("FAIL mulrst_async got v=%b out=%h exp 0 00", b8.out_valid, b8.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mulrst_release got rdy=%b v=%b exp 1 0", b8.in_ready, b8.out_valid);
        end
        repeat (15) begin
            @(negedge clk);
            if (b8.out_valid !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL mulrst_stale got %0d valid cycles exp 0", stale);
        end
    endtask

    task automatic test_shift16();
        b16.ctrl = OP_SRA; b16.x = 16'h0004; b16.y = 16'h8000; b16.in_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (b16.out_valid !== 1'b1 || b16.out !== 16'hF800) begin
            n_fail++;
            $display("FAIL sra16 got v=%b out=%h exp 1 f800", b16.out_valid, b16.out);
        end
        b16.ctrl = OP_SLL; b16.x = 16'h0013; b16.y = 16'h0001;
        @(negedge clk);
        b16.in_valid = 1'b0;
        n_tests++;
        if (b16.out_valid !== 1'b1 || b16.out !== 16'h0008) begin
            n_fail++;
            $display("FAIL sll16 got v=%b out=%h exp 1 0008", b16.out_valid, b16.out);
        end
        @(negedge clk);
    endtask

    initial begin
        b8.in_valid = 1'b0;  b8.ctrl = OP_NOP;  b8.x = '0;  b8.y = '0;  b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.ctrl = OP_NOP; b16.x = '0; b16.y = '0; b16.out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_logic_shift();
        test_back_to_back();
        test_mul();
        test_backpressure();
        test_mul_reset();
        test_shift16();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL have parameter: SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).
REQ-003 SHALL have port: clk  input  1  single rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: in_valid  input  1  operation request valid.
REQ-006 SHALL have port: in_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port: ctrl  input  4  opcode.
REQ-008 SHALL have ports: x, y  input  WIDTH  operands.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have ports: out  output  WIDTH  result; out_hi  output  WIDTH  upper product half (MUL only, else 0).
REQ-012 SHALL have ports: carry, ovf, zero  output  1 each  flags registered with out.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT x, 5 XOR, 6 NOR, 7 SLL y by x[SHW-1:0], 8 SRL y by x[SHW-1:0], 9 SRA x by 1, 10 ROL x by 1, 11 ROR x by 1, 12 EQ (out=1 if x==y else 0), 13 MUL unsigned, 14 SRA y by x[SHW-1:0], 15 NOP (out=0).
REQ-014 Handshake: request accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-016 FSM states: IDLE, MUL, HOLD; IDLE->MUL on accepted op 13; MUL->HOLD after WIDTH iterations; HOLD->IDLE when result consumed; non-MUL ops stay in IDLE.
REQ-017 Non-MUL latency SHALL be 1 cycle: out_valid rises on the edge after acceptance.
REQ-018 MUL latency SHALL be WIDTH+1 cycles, one shift-add iteration per cycle; out_valid asserts on entry to HOLD.
REQ-019 Back-to-back non-MUL ops SHALL sustain one per cycle when out_ready stays high.
REQ-020 Result and flags SHALL hold stable while out_valid && !out_ready.
REQ-021 ADD: carry = bit WIDTH of unsigned x+y; ovf = signed overflow.
REQ-022 SUB: carry = borrow (1 when x<y unsigned); ovf = signed overflow.
REQ-023 MUL: {out_hi,out} = x*y (2*WIDTH bits); carry = (out_hi!=0); ovf=0.
REQ-024 All other ops: carry=0, ovf=0, out_hi=0.
REQ-025 zero SHALL be 1 iff out==0 (out_hi ignored).
REQ-026 Shift amounts SHALL use only x[SHW-1:0]; higher x bits ignored.
REQ-027 Operands for MUL SHALL be captured at acceptance; x/y changes during MUL have no effect.
REQ-028 in_valid while in_ready=0 SHALL be ignored (not queued).

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, out_valid=0, out=0, out_hi=0, carry=0, ovf=0, zero=0, multiplier registers=0.
REQ-030 Reset mid-MUL SHALL abandon the operation; no result emitted after release.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package alu_pkg SHALL hold opcode constants (OP_ADD..OP_NOP) and FSM state encoding.
REQ-033 Multiplier SHALL be sub-module alu_mul_seq (start, busy, done, WIDTH-parametrised shift-add).
REQ-034 Single-cycle datapath SHALL be combinational, feeding one output register stage.

Verification
REQ-035 WIDTH=8: ADD x=0xFF y=0x01 -> next cycle out=0x00, carry=1, zero=1, ovf=0.
REQ-036 WIDTH=8: SUB x=0x80 y=0x01 -> out=0x7F, carry=0, ovf=1; SUB x=0x01 y=0x02 -> out=0xFF, carry=1.
REQ-037 WIDTH=8: MUL x=0xFF y=0xFF -> out_valid exactly 9 cycles after accept, out=0x01, out_hi=0xFE, carry=1; in_ready=0 throughout.
REQ-038 WIDTH=16: SRA ctrl=14 x=0x0004 y=0x8000 -> out=0xF800; SLL ctrl=7 x=0x0013 y=0x0001 -> out=0x0008.
REQ-039 Backpressure: ADD result with out_ready=0 for 3 cycles -> out stable, in_ready=0; then EQ x=y=0x5A accepted same cycle out_ready=1 -> out=0x01.
REQ-040 rst_n pulsed low at cycle 4 of MUL -> out_valid=0, in_ready=1 after release, no stale result.
